// File: rtl/ram2_ctrl_pkg.sv
// State, owner and strobe definitions shared by the RAM2 SRAM sequencer.
package ram2_ctrl_pkg;

  typedef enum logic [2:0] {
    Ram2Idle    = 3'd0,
    Ram2RdAddr  = 3'd1,
    Ram2RdData  = 3'd2,
    Ram2WrAddr  = 3'd3,
    Ram2WrPulse = 3'd4,
    Ram2WrHold  = 3'd5
  } ram2_state_e;

  typedef enum logic {
    Ram2OwnerIF  = 1'b0,
    Ram2OwnerMEM = 1'b1
  } ram2_owner_e;

  localparam logic Ram2StrobeOn  = 1'b0;
  localparam logic Ram2StrobeOff = 1'b1;

  typedef struct packed {
    logic en_n;
    logic oe_n;
    logic we_n;
    logic data_oe;
  } ram2_strobe_t;

  localparam ram2_strobe_t Ram2StrobeIdle = '{
    en_n: Ram2StrobeOff, oe_n: Ram2StrobeOff, we_n: Ram2StrobeOff, data_oe: 1'b0
  };

  // Pin strobes to present while the FSM sits in state s.
  function automatic ram2_strobe_t ram2_strobes(input ram2_state_e s);
    ram2_strobe_t v;
    v = Ram2StrobeIdle;
    case (s)
      Ram2RdAddr, Ram2RdData: begin
        v.en_n = Ram2StrobeOn;
        v.oe_n = Ram2StrobeOn;
      end
      Ram2WrAddr, Ram2WrHold: begin
        v.en_n    = Ram2StrobeOn;
        v.data_oe = 1'b1;
      end
      Ram2WrPulse: begin
        v.en_n    = Ram2StrobeOn;
        v.we_n    = Ram2StrobeOn;
        v.data_oe = 1'b1;
      end
      default: v = Ram2StrobeIdle;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ram2_ctrl.sv
// Single-port RAM2 sequencer/arbiter for IF fetches and MEM loads/stores; strobes are registered.
// Build option RAM2_FAST_READ_EN: skip RD_DATA, capturing read data at the end of RD_ADDR.
module ram2_ctrl
  import ram2_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] pc,
  output logic [15:0] inst,
  output logic        inst_valid,
  input  logic        mem_re,
  input  logic        mem_we,
  input  logic [15:0] mem_addr_i,
  input  logic [15:0] mem_data_i,
  output logic [15:0] mem_data_o,
  output logic        mem_done,
  output logic        if_stall,
  output logic        mem_stall,
  output logic [17:0] ram2_addr,
  input  logic [15:0] ram2_data_i,
  output logic [15:0] ram2_data_o,
  output logic        ram2_data_oe,
  output logic        ram2_en_n,
  output logic        ram2_oe_n,
  output logic        ram2_we_n
);

  ram2_state_e  r_state, w_state_nxt;
  ram2_owner_e  r_owner;
  ram2_strobe_t r_strb;
  logic [15:0]  r_addr, r_wdata, r_inst, r_mem_rdata;
  logic         r_inst_valid, r_mem_done;
  logic         w_grant, w_grant_mem, w_grant_we, w_rd_last, w_wr_last;
  logic         w_mem_we_vis, w_mem_re_vis, w_if_req_vis;

  // A request is still held during its own completion cycle; never serve it twice.
  assign w_mem_we_vis = mem_we & ~r_mem_done;
  assign w_mem_re_vis = mem_re & ~r_mem_done;
  assign w_if_req_vis = if_req & ~r_inst_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_mem = 1'b0;
    w_grant_we  = 1'b0;
    w_rd_last   = 1'b0;
    w_wr_last   = 1'b0;
    case (r_state)
      Ram2Idle: begin
        if (w_mem_we_vis) begin
          w_state_nxt = Ram2WrAddr;
          w_grant     = 1'b1;
          w_grant_mem = 1'b1;
          w_grant_we  = 1'b1;
        end else if (w_mem_re_vis) begin
          w_state_nxt = Ram2RdAddr;
          w_grant     = 1'b1;
          w_grant_mem = 1'b1;
        end else if (w_if_req_vis) begin
          w_state_nxt = Ram2RdAddr;
          w_grant     = 1'b1;
        end
      end
      Ram2RdAddr: begin
`ifdef RAM2_FAST_READ_EN
        w_state_nxt = Ram2Idle;
        w_rd_last   = 1'b1;
`else
        w_state_nxt = Ram2RdData;
`endif
      end
      Ram2RdData: begin
        w_state_nxt = Ram2Idle;
        w_rd_last   = 1'b1;
      end
      Ram2WrAddr:  w_state_nxt = Ram2WrPulse;
      Ram2WrPulse: w_state_nxt = Ram2WrHold;
      Ram2WrHold: begin
        w_state_nxt = Ram2Idle;
        w_wr_last   = 1'b1;
      end
      default: w_state_nxt = Ram2Idle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= Ram2Idle;
      r_owner      <= Ram2OwnerIF;
      r_strb       <= Ram2StrobeIdle;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_inst       <= '0;
      r_mem_rdata  <= '0;
      r_inst_valid <= 1'b0;
      r_mem_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_strb       <= ram2_strobes(w_state_nxt);
      r_inst_valid <= w_rd_last & (r_owner == Ram2OwnerIF);
      r_mem_done   <= (w_rd_last & (r_owner == Ram2OwnerMEM)) | w_wr_last;
      if (w_rd_last) begin
        if (r_owner == Ram2OwnerIF) r_inst      <= ram2_data_i;
        else                        r_mem_rdata <= ram2_data_i;
      end
      if (w_grant) begin
        r_addr  <= w_grant_mem ? mem_addr_i : pc;
        r_owner <= w_grant_mem ? Ram2OwnerMEM : Ram2OwnerIF;
      end
      if (w_grant_we) r_wdata <= mem_data_i;
    end
  end

  assign inst         = r_inst;
  assign inst_valid   = r_inst_valid;
  assign mem_data_o   = r_mem_rdata;
  assign mem_done     = r_mem_done;
  assign if_stall     = if_req & ~r_inst_valid;
  assign mem_stall    = (mem_re | mem_we) & ~r_mem_done;
  assign ram2_addr    = {2'b00, r_addr};
  assign ram2_data_o  = r_wdata;
  assign ram2_data_oe = r_strb.data_oe;
  assign ram2_en_n    = r_strb.en_n;
  assign ram2_oe_n    = r_strb.oe_n;
  assign ram2_we_n    = r_strb.we_n;

endmodule

// File: tb/tb_ram2_ctrl.sv
// Directed + randomized bench for ram2_ctrl with an SRAM pin model and a memory-array reference.
module tb_ram2_ctrl;

`ifdef RAM2_FAST_READ_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [15:0] pc = '0;
  logic [15:0] inst;
  logic        inst_valid;
  logic        mem_re = 1'b0;
  logic        mem_we = 1'b0;
  logic [15:0] mem_addr_i = '0;
  logic [15:0] mem_data_i = '0;
  logic [15:0] mem_data_o;
  logic        mem_done;
  logic        if_stall, mem_stall;
  logic [17:0] ram2_addr;
  logic [15:0] ram2_data_i;
  logic [15:0] ram2_data_o;
  logic        ram2_data_oe, ram2_en_n, ram2_oe_n, ram2_we_n;

  ram2_ctrl dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .pc(pc), .inst(inst), .inst_valid(inst_valid),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr_i(mem_addr_i), .mem_data_i(mem_data_i),
    .mem_data_o(mem_data_o), .mem_done(mem_done),
    .if_stall(if_stall), .mem_stall(mem_stall),
    .ram2_addr(ram2_addr), .ram2_data_i(ram2_data_i), .ram2_data_o(ram2_data_o),
    .ram2_data_oe(ram2_data_oe), .ram2_en_n(ram2_en_n), .ram2_oe_n(ram2_oe_n),
    .ram2_we_n(ram2_we_n)
  );

  always #5 clk = ~clk;

  // SRAM pin model: asynchronous read, write latched on the rising edge of we_n.
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  assign ram2_data_i = (!ram2_en_n && !ram2_oe_n) ? sram[ram2_addr[15:0]] : 16'h0BAD;
  always @(posedge ram2_we_n)
    if (rst && !ram2_en_n && ram2_data_oe) sram[ram2_addr[15:0]] = ram2_data_o;

  int checks = 0, errors = 0, viol = 0, spurious = 0;
  always @(negedge clk)
    if (rst === 1'b1) begin
      if (!ram2_oe_n && !ram2_we_n) viol++;
      if (ram2_data_oe && !ram2_oe_n) viol++;
    end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit          if_busy = 0, mem_busy = 0, mem_is_wr = 0;
  logic [15:0] if_exp, mem_exp;
  int          if_wait, mem_wait;
  int          n_if_iss = 0, n_if_done = 0, n_mem_iss = 0, n_mem_done = 0;

  task automatic rand_cycle(input bit allow_new);
    tick();
    if (inst_valid) begin
      if (!if_busy) spurious++;
      else begin
        check("rnd_inst", inst, if_exp);
        if_busy = 0; if_req = 0; n_if_done++;
      end
    end
    if (mem_done) begin
      if (!mem_busy) spurious++;
      else begin
        if (!mem_is_wr) check("rnd_load", mem_data_o, mem_exp);
        mem_busy = 0; mem_we = 0; mem_re = 0; n_mem_done++;
      end
    end
    if (if_busy) begin
      if_wait++;
      if (if_wait > 40) begin
        check("rnd_if_timeout", inst_valid, 1);
        if_busy = 0; if_req = 0;
      end
    end
    if (mem_busy) begin
      mem_wait++;
      if (mem_wait > 40) begin
        check("rnd_mem_timeout", mem_done, 1);
        mem_busy = 0; mem_we = 0; mem_re = 0;
      end
    end
    if (allow_new && !if_busy && $urandom_range(0, 2) == 0) begin
      pc = 16'($urandom_range(0, 255));
      if_exp = ref_mem[pc];
      if_req = 1; if_busy = 1; if_wait = 0; n_if_iss++;
    end
    if (allow_new && !mem_busy && $urandom_range(0, 2) == 0) begin
      mem_addr_i = 16'h8000 + 16'($urandom_range(0, 15));
      mem_is_wr  = 1'($urandom_range(0, 1));
      if (mem_is_wr) begin
        mem_data_i = 16'($urandom);
        ref_mem[mem_addr_i] = mem_data_i;
        mem_we = 1;
      end else begin
        mem_exp = ref_mem[mem_addr_i];
        mem_re = 1;
      end
      mem_busy = 1; mem_wait = 0; n_mem_iss++;
    end
  endtask

  initial begin
    int  we_low;
    bit  oe_ok, stable_ok, early, stall_ok;
    for (int i = 0; i < 256; i++) begin
      sram[i] = 16'($urandom);            ref_mem[i] = sram[i];
      sram[16'h8000 + i] = 16'($urandom); ref_mem[16'h8000 + i] = sram[16'h8000 + i];
    end
    sram[3] = 16'h3120; ref_mem[3] = 16'h3120;

    // Reset values
    #12;
    check("rst_inst", inst, 0);
    check("rst_mem_data", mem_data_o, 0);
    check("rst_strobes", {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe}, 4'b1110);
    check("rst_addr", ram2_addr, 0);
    check("rst_pulses", {inst_valid, mem_done}, 2'b00);
    rst = 1;
    tick();

    // IF read
    if_req = 1; pc = 16'h0003; #1;
    check("if_stall_req", if_stall, 1);
    early = 0;
    for (int k = 1; k <= RD_LAT; k++) begin
      tick();
      if (k == 1) begin
        check("if_addr", ram2_addr, 18'h00003);
        check("if_rd_strobes", {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe}, 4'b0010);
      end
      if (k < RD_LAT && inst_valid) early = 1;
    end
    check("if_no_early_pulse", early, 0);
    check("if_pulse", inst_valid, 1);
    check("if_data", inst, 16'h3120);
    check("if_stall_release", if_stall, 0);
    if_req = 0;
    tick();
    check("if_pulse_single", inst_valid, 0);
    check("if_inst_hold", inst, 16'h3120);
    check("if_idle_strobes", {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe}, 4'b1110);

    // MEM write
    mem_we = 1; mem_addr_i = 16'h8005; mem_data_i = 16'hBEEF;
    we_low = 0; oe_ok = 1; stable_ok = 1; early = 0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k < 4) begin
        if (!ram2_we_n) we_low++;
        if (!ram2_data_oe) oe_ok = 0;
        if (ram2_addr != 18'h08005 || ram2_data_o != 16'hBEEF) stable_ok = 0;
        if (mem_done) early = 1;
      end
      if (k == 2) check("wr_pulse_cycle", ram2_we_n, 0);
    end
    check("wr_no_early_done", early, 0);
    check("wr_done", mem_done, 1);
    check("wr_we_low_cycles", we_low, 1);
    check("wr_data_oe", oe_ok, 1);
    check("wr_addr_data_stable", stable_ok, 1);
    mem_we = 0; ref_mem[16'h8005] = 16'hBEEF;
    tick();
    check("wr_idle_strobes", {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe}, 4'b1110);

    // Read back the written word
    mem_re = 1; mem_addr_i = 16'h8005;
    repeat (RD_LAT) tick();
    check("rb_done", mem_done, 1);
    check("rb_data", mem_data_o, 16'hBEEF);
    mem_re = 0;
    tick();

    // IF and MEM in the same cycle
    if_req = 1; pc = 16'h0003; mem_re = 1; mem_addr_i = 16'h8005; stall_ok = 1;
    for (int k = 1; k <= 2 * RD_LAT; k++) begin
      tick();
      if (k < 2 * RD_LAT && !if_stall) stall_ok = 0;
      if (k == RD_LAT) begin
        check("cf_mem_first", mem_done, 1);
        check("cf_if_waits", inst_valid, 0);
        mem_re = 0;
      end
    end
    check("cf_if_pulse", inst_valid, 1);
    check("cf_if_data", inst, 16'h3120);
    check("cf_if_stall_held", stall_ok, 1);
    if_req = 0;
    tick();

    // Reset asserted during WR_PULSE
    mem_we = 1; mem_addr_i = 16'h8010; mem_data_i = 16'h1234;
    tick(); tick();
    check("rw_in_pulse", ram2_we_n, 0);
    #2 rst = 0;
    #1;
    check("rw_async_we", ram2_we_n, 1);
    check("rw_async_oe", ram2_data_oe, 0);
    mem_we = 0;
    tick();
    rst = 1;
    #1;
    check("rw_inst", inst, 0);
    check("rw_mem_data", mem_data_o, 0);
    check("rw_addr", ram2_addr, 0);
    check("rw_wdata", ram2_data_o, 0);
    check("rw_pulses", {inst_valid, mem_done}, 2'b00);
    tick();
    check("rw_idle_strobes", {ram2_en_n, ram2_oe_n, ram2_we_n, ram2_data_oe}, 4'b1110);

    // Random IF/MEM mix
    repeat (1000) rand_cycle(1);
    for (int i = 0; i < 60 && (if_busy || mem_busy); i++) rand_cycle(0);
    repeat (4) rand_cycle(0);
    check("rnd_if_all_served", n_if_done, n_if_iss);
    check("rnd_mem_all_served", n_mem_done, n_mem_iss);
    check("rnd_no_spurious", spurious, 0);
    check("strobe_overlap", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram2_ctrl.md
# ram2_ctrl

Sequencer and arbiter for the single-port RAM2 SRAM, which is shared between instruction fetch (IF) and the MEM stage. It serialises IF fetches and MEM loads/stores onto one SRAM port, drives the SRAM control strobes with correct setup/hold phasing, and returns per-requester completion pulses. Stall outputs freeze the pipeline while an access is outstanding. It sits between the CPU core and the board-level RAM2 pins; the top level builds the tri-state data bus from the `ram2_data_o`/`ram2_data_oe` pair.

## Interface
- No parameters; widths come from `defines.v` (`DataAddrBus` and `DataBus`/`InstBus` are 16 bits).
- `clk  in  1`: system clock; all state changes on the rising edge.
- `rst  in  1`: reset, asynchronous, active-low.
- `if_req  in  1`: IF requests a fetch at `pc`; held until `inst_valid`.
- `pc  in  16`: fetch address.
- `inst  out  16`: fetched instruction; registered, holds its value until the next IF read.
- `inst_valid  out  1`: one-cycle pulse when `inst` has been updated.
- `mem_re  in  1`: MEM load request; held until `mem_done`.
- `mem_we  in  1`: MEM store request; held until `mem_done`. Takes priority over `mem_re` if both are high.
- `mem_addr_i  in  16`: MEM address.
- `mem_data_i  in  16`: store data.
- `mem_data_o  out  16`: load data; registered, holds its value.
- `mem_done  out  1`: one-cycle pulse when a MEM access completes.
- `if_stall  out  1`: combinational, `if_req & ~inst_valid`.
- `mem_stall  out  1`: combinational, `(mem_re|mem_we) & ~mem_done`.
- `ram2_addr  out  18`: SRAM address, `{2'b00, addr}`.
- `ram2_data_i  in  16`: SRAM read data.
- `ram2_data_o  out  16`: SRAM write data.
- `ram2_data_oe  out  1`: data bus drive enable.
- `ram2_en_n  out  1`: SRAM chip enable, active low.
- `ram2_oe_n  out  1`: SRAM output enable, active low.
- `ram2_we_n  out  1`: SRAM write enable, active low.

## Operation
- **States:** IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_PULSE, WR_HOLD.
- **Arbitration in IDLE**, in priority order:
  - `mem_we` → WR_ADDR.
  - else `mem_re` → RD_ADDR with owner MEM.
  - else `if_req` → RD_ADDR with owner IF.
  - On grant, latch address, store data and owner; requester inputs are not used again until the next grant.
- **RD_ADDR:** `en_n=0`, `oe_n=0`, `data_oe=0`.
- **RD_DATA:** same strobes. On exit, capture `ram2_data_i` into `inst` or `mem_data_o` according to owner, then return to IDLE.
- **WR_ADDR:** `en_n=0`, `data_oe=1`, `we_n=1`.
- **WR_PULSE:** `we_n=0`.
- **WR_HOLD:** `we_n=1`, data still driven, then return to IDLE.
- **Completion pulse:** `inst_valid`/`mem_done` is high for the single cycle after the final state, while the FSM is back in IDLE. A new grant can be taken in that same cycle.
- **Idle strobes:** `en_n=1`, `oe_n=1`, `we_n=1`, `data_oe=0`, `ram2_addr` holds its last value.
- **Request dropped mid-access:** the access still completes and the pulse is still issued; the requester ignores it.
- **Simultaneous IF+MEM:** MEM is served first. IF is granted in the IDLE cycle that carries `mem_done`, unless MEM re-requests.
- **Strobe overlap:** `oe_n` and `we_n` are never low together. `data_oe` is never high while `oe_n=0`.

## Timing
- **Reset values:** state IDLE; `inst=0`, `mem_data_o=0`, pulses 0; `en_n=oe_n=we_n=1`; `data_oe=0`; `ram2_addr=0`, `ram2_data_o=0`.
- **Reset mid-write:** `we_n` rises and `data_oe` falls immediately (asynchronous).
- **Read latency:** request seen in IDLE at cycle 0 → pulse in cycle 3. Back-to-back throughput is one read per 3 cycles.
- **Write latency:** request at cycle 0 → `mem_done` in cycle 4.
- **Write phasing:** address and data are stable one full cycle before `we_n` falls and one full cycle after it rises.

## Configuration
- **`RAM2_FAST_READ_EN` defined:** RD_DATA is skipped. Data is captured at the exit of RD_ADDR; read latency is 2 cycles (pulse in cycle 2).
- **Undefined:** 2-state read as above. Write timing is unchanged in both builds.

## Structure
- **`defines.v` additions:**
  - State encodings (`Ram2Idle` … `Ram2WrHold`, 3 bits).
  - Owner encodings `Ram2OwnerIF`/`Ram2OwnerMEM`.
  - Active-low strobe constants `Ram2StrobeOn=1'b0` / `Ram2StrobeOff=1'b1`.
- **No sub-module:** the FSM, latches and output registers form a single module.

## Test plan
- **Reset:** reset asserted mid-WR_PULSE → `we_n=1` and `data_oe=0` with no clock edge; after release, state IDLE and all outputs at reset values.
- **IF read:** `if_req=1`, `pc=16'h0003`, SRAM model holds `16'h3120` → `ram2_addr=18'h00003`, `inst=16'h3120`, `inst_valid` pulses in cycle 3 (cycle 2 with `RAM2_FAST_READ_EN`).
- **MEM write:** `mem_we=1`, `mem_addr_i=16'h8005`, `mem_data_i=16'hBEEF` → `we_n` low in exactly one cycle with `data_oe=1` across WR_ADDR..WR_HOLD, `mem_done` in cycle 4; a later read of `16'h8005` returns `16'hBEEF`.
- **Conflict:** `if_req` and `mem_re` raised in the same cycle → MEM read completes first (`mem_done` cycle 3), then IF is granted; `inst_valid` arrives in cycle 6; `if_stall` stays high throughout.
- **Strobe check:** random IF/MEM mix over 1000 cycles → `oe_n`/`we_n` never low together, `data_oe` never high while `oe_n=0`, every request gets exactly one pulse.
